// File: rtl/mults_pkg.sv
// Shared definitions for the signed MAC accumulation path: default widths,
// the accumulator FSM state type and the saturation bounds.
package mults_pkg;

  // Product width coming out of the signed 8x8 multiplier.
  localparam int PROD_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Largest value representable in a signed accumulator of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed accumulator of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mults_mac_accum_if.sv
// Handshake bundle between the product producer, the accumulator and the
// result consumer.
interface mults_mac_accum_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
) ();

  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] product;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     sat;
  logic                     busy;

  modport slave (
    input  start, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, sat, busy
  );

  modport master (
    output start, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, sat, busy
  );

endinterface

// File: rtl/mults_sat_add.sv
// Saturating signed adder: acc + sign-extended product, clamped to the
// signed range of the accumulator, with an overflow indication.
module mults_sat_add
  import mults_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  product,
  output logic signed [ACC_W-1:0] sum,
  output logic                    overflow
);

  localparam logic signed [ACC_W:0] MAX_VAL = (ACC_W + 1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MIN_VAL = (ACC_W + 1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - IN_W){product[IN_W-1]}}, product};

  // One extra bit of headroom makes the out-of-range check exact.
  always_comb begin
    sum      = wide[ACC_W-1:0];
    overflow = 1'b0;
    if (wide > MAX_VAL) begin
      sum      = MAX_VAL[ACC_W-1:0];
      overflow = 1'b1;
    end else if (wide < MIN_VAL) begin
      sum      = MIN_VAL[ACC_W-1:0];
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/mults_mac_accum.sv
// Frame accumulator: sums FRAME_LEN signed products with saturation and
// presents the sum plus a sticky saturation flag on a valid/ready port.
module mults_mac_accum
  import mults_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEFAULT,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  mults_mac_accum_if.slave    bus
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic [7:0]              count;
  logic                    sat_r;
  logic                    out_valid_r;
  logic                    take;

  // A pending start blocks acceptance so no product falls into a frame being cleared.
  assign bus.in_ready  = (state == ACCUM) && !bus.start;
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state == ACCUM);
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc;
  assign bus.sat       = sat_r;

  mults_sat_add #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc      (acc),
    .product  (bus.product),
    .sum      (sum),
    .overflow (ovf)
  );

  // Frame FSM with the accumulator, product count and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            sat_r <= 1'b0;
          end
        end
        ACCUM: begin
          if (bus.start) begin
            acc   <= '0;
            count <= '0;
            sat_r <= 1'b0;
          end else if (take) begin
            acc   <= sum;
            sat_r <= sat_r | ovf;
            count <= count + 8'd1;
            if (count == LAST_IDX) begin
              state       <= HOLD;
              out_valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.start) begin
              state <= ACCUM;
              acc   <= '0;
              count <= '0;
              sat_r <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mults_mac_accum.md
Name: mults_mac_accum

Overview:
Downstream consumer of the signed 8x8 structural multiplier (MULTS_signed). It accepts one signed 16-bit product per valid/ready handshake and accumulates a frame of FRAME_LEN products into a saturating signed accumulator. It then presents the frame sum with a sticky saturation flag on a valid/ready output port. Together with the multiplier, it forms the dot-product / MAC path of the signed datapath.

Parameters:
PROD_W, 16, product width; must equal the multiplier result width (2x operand width).
ACC_W, 24, accumulator/output width; must satisfy ACC_W >= PROD_W.
FRAME_LEN, 8, number of products per frame; range 1..255.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse: clear the accumulator and open a new frame.
in_valid  input  1  product is valid this cycle.
in_ready  output  1  block accepts a product this cycle.
product  input  PROD_W  signed product from MULTS_signed.result.
out_valid  output  1  frame result is valid.
out_ready  input  1  consumer takes the result.
acc_out  output  ACC_W  signed frame sum.
sat  output  1  sticky flag: saturation occurred at least once during this frame.
busy  output  1  high in ACCUM.

Behaviour:
- Reset (rst=1 at clk edge, in any state): state=IDLE, acc=0, count=0, sat=0, out_valid=0. busy=0 and in_ready=0 follow from the state.
- States are IDLE, ACCUM and HOLD.
  - IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM with acc=0, count=0, sat=0.
  - ACCUM: in_ready = !start. A transfer occurs when in_valid && in_ready. On a transfer, acc <= sat_add(acc, sign-extended product) and count++. The transfer that makes count==FRAME_LEN moves the state to HOLD.
  - start=1 in ACCUM: restart the frame (acc=0, count=0, sat=0, stay in ACCUM). in_ready is low that cycle, so no product is lost.
  - HOLD: out_valid=1; acc_out and sat are held stable until the transfer. out_valid && out_ready -> IDLE. If start=1 in the same cycle, go directly to ACCUM (cleared) instead.
  - start=1 in HOLD without out_ready is ignored; the result is never dropped.
- Latency: out_valid rises in the cycle after the edge that accepts the FRAME_LEN-th product. Minimum frame time is FRAME_LEN+1 cycles from the start edge.
- acc_out always reflects the acc register and is only meaningful while out_valid=1.
- Arithmetic: two's complement. product is sign-extended to ACC_W+1 bits, added, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On a clamp, sat <= 1. sat stays set until the next start or reset.
  - After saturation, accumulation continues from the clamped value.
- in_valid while in IDLE or HOLD: no transfer occurs and the product is ignored. The upstream stage must hold its data.
- Products with in_valid low do not change acc or count.

Decomposition:
- Package mults_pkg holds:
  - PROD_W default constant;
  - the state enum (IDLE, ACCUM, HOLD);
  - saturation bound constants as functions of ACC_W.
- One combinational sub-module, mults_sat_add (params IN_W, ACC_W):
  - inputs acc and product;
  - outputs the clamped sum and an overflow bit.
- The top module holds the FSM, count, acc and sat registers.

Test Plan:
1. Nominal frame: drive MULTS_signed with A=7i, X=11i for i=1..8 into product, in_valid continuous, FRAME_LEN=8. Expect out_valid one cycle after the 8th accept, acc_out = 77*204 = 15708, sat=0.
2. Positive saturation: ACC_W=16, FRAME_LEN=3, products 16129 (127*127) x3. Expect acc_out=32767, sat=1. A following start clears sat to 0.
3. Negative saturation: ACC_W=16, FRAME_LEN=3, products -16256 (-128*127) x3. Expect acc_out=-32768, sat=1.
4. Gaps and backpressure: toggle in_valid every other cycle, then hold out_ready=0 for 5 cycles in HOLD. Expect in_ready=0 throughout HOLD, acc_out stable, and exactly one result transfer when out_ready=1.
5. Restart and back-to-back:
   - start after 3 accepted products: acc clears, and the final sum covers only the next FRAME_LEN products;
   - start together with out_ready in HOLD: enters ACCUM directly with acc=0.
6. Reset mid-frame: rst=1 for one cycle after 4 products. Expect the IDLE outputs (out_valid=0, busy=0, in_ready=0, acc_out=0). A subsequent frame with products 1..8 yields 36.
